upsp_frame_ctrl: RTL
====================

Name: upsp_frame_ctrl

Overview:
- Frame-level sequencer wrapped around the bicubic upsampling core (buffer + R/G/B upsample channels).
- Gates the AXI-side read and write handshakes so exactly one frame of cfg_width x cfg_height source pixels enters the core per start command.
- Counts the 2x2 output blocks leaving the core and tags end-of-line / end-of-frame on the write stream.
- Reports busy/done plus a sticky protocol-error flag to the access-control host logic.

Parameters:
- DIM_W, 12, bit width of the width/height configuration and the x/y counters.
- BUFFER_WIDTH, 24, packed RGB pixel width; the output block is BUFFER_WIDTH*4 bits.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle frame start; ignored unless state is IDLE.
- cfg_width  in  DIM_W  source pixels per line; sampled at accepted start.
- cfg_height  in  DIM_W  source lines per frame; sampled at accepted start.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when the frame completes.
- err  out  1  sticky; set on a protocol violation; cleared only by an accepted cfg_start.
- src_rvalid  in  1  source pixel valid (AXI read side).
- src_rready  out  1  = core_rready when input gate open, else 0.
- core_rvalid  out  1  = src_rvalid when input gate open, else 0 (data passes through externally).
- core_rready  in  1  upsp_ac_rready from core.
- core_wvalid  in  1  upsp_ac_wvalid from core.
- core_wready  out  1  = sink_wready when output gate open, else 0.
- sink_wvalid  out  1  = core_wvalid when output gate open, else 0.
- sink_wready  in  1  downstream write ready.
- sink_eol  out  1  high with sink_wvalid on the last block of a source line.
- sink_eof  out  1  high with sink_wvalid on the last block of the frame.

Behaviour:
- Reset: state IDLE. busy=0, done=0, err=0, src_rready=0, core_rvalid=0, core_wready=0, sink_wvalid=0, sink_eol=0, sink_eof=0. All counters 0.
- in_hsk = src_rvalid & src_rready. out_hsk = sink_wvalid & sink_wready.

States:
- IDLE:
  - cfg_start with width>=1 and height>=1 latches cfg, clears counters and err -> RUN.
  - cfg_start with a zero dimension sets err and stays IDLE; done stays 0.
- RUN:
  - Input gate open until in_x/in_y reach (W-1, H-1) with in_hsk; then input gate closes the next cycle -> DRAIN.
  - Output gate is open throughout RUN and DRAIN.
- DRAIN: input gate closed; wait for the final out_hsk with sink_eof -> DONE.
- DONE: done=1 for exactly one cycle; gates closed -> IDLE.
- A final out_hsk in the same cycle as the final in_hsk is impossible by construction. If it occurs, transition RUN -> DONE directly and set err.

Counters:
- in_x/in_y increment on in_hsk; in_x wraps at W-1 and increments in_y.
- out_x/out_y behave identically on out_hsk.
- sink_eol = (out_x==W-1). sink_eof = sink_eol & (out_y==H-1). Both are combinational from the counters and qualified by the output gate.

Errors (set err, no state change):
- core_wvalid high while state is IDLE or DONE.
- cfg_start while busy (the start is ignored).

Rules:
- Gating is purely combinational; zero added latency on either handshake; no data storage in this block.
- Valid must not depend on ready: sink_wvalid depends only on core_wvalid and state.
- Reset mid-frame: everything returns to reset values asynchronously. The core is reset by the same rst_n.
- Widths: counters DIM_W bits; maximum frame 2^DIM_W-1 in each dimension.

Decomposition:
- Package upsp_pkg: state encoding localparams (ST_IDLE=0, ST_RUN=1, ST_DRAIN=2, ST_DONE=3) and default DIM_W.
- One natural sub-module, upsp_xy_cnt: x/y counter with wrap, last_x/last_y flags, and a clear input. Instantiated twice, for input and output.

Test Plan:
- W=4, H=2, src_rvalid/core/sink always ready:
  - 8 in_hsk, then src_rready=0.
  - 8 out_hsk with sink_eol on blocks 4 and 8; sink_eof only on block 8.
  - done pulses one cycle after block 8; busy falls with it.
- Same frame with sink_wready toggling 1-0-1-0: core_wready mirrors sink_wready, no block lost, eol/eof stable while stalled, done still after the 8th out_hsk.
- cfg_start during RUN: ignored, err=1, frame completes normally. Next accepted cfg_start clears err.
- cfg_width=0, cfg_start: err=1, state stays IDLE, busy=0, done never asserted.
- rst_n low after 3 of 8 inputs: all outputs 0 immediately. After release, a new W=1, H=1 frame yields 1 in_hsk, 1 out_hsk with eol=eof=1, then done.
- core_wvalid forced high in IDLE: sink_wvalid stays 0, core_wready stays 0, err=1.

Source files
------------

// File: rtl/upsp_pkg.sv
// Shared definitions for the upsampling frame controller.
//   upsp_state_e : frame sequencer state encoding
//   UPSP_DIM_W   : default width of the dimension configuration and counters
package upsp_pkg;

  localparam int UPSP_DIM_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } upsp_state_e;

endpackage

// File: rtl/upsp_xy_cnt.sv
// Raster x/y position counter.
//   clk, rst_n     : clock, asynchronous active-low reset
//   clr            : synchronous clear to (0,0), takes priority over inc
//   inc            : advance one position; x wraps at max_x and bumps y,
//                    y wraps at max_y
//   max_x, max_y   : last valid x / y index
//   last_x, last_y : current position is on the last column / last line
module upsp_xy_cnt #(
  parameter int DIM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [DIM_W-1:0] max_x,
  input  logic [DIM_W-1:0] max_y,
  output logic             last_x,
  output logic             last_y
);

  logic [DIM_W-1:0] x_q, x_d;
  logic [DIM_W-1:0] y_q, y_d;

  assign last_x = (x_q == max_x);
  assign last_y = (y_q == max_y);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (inc) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_q + DIM_W'(1);
      end else begin
        x_d = x_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/upsp_frame_ctrl.sv
// Frame-level sequencer around the bicubic upsampling core.
// Lets exactly cfg_width x cfg_height source pixels into the core per start,
// counts output blocks, tags end-of-line/end-of-frame, and reports status.
//   cfg_start/cfg_width/cfg_height : frame start command and dimensions
//   busy/done/err                  : status (err is sticky until a good start)
//   src_rvalid/src_rready          : source read handshake (gated)
//   core_rvalid/core_rready        : core read handshake (gated)
//   core_wvalid/core_wready        : core write handshake (gated)
//   sink_wvalid/sink_wready        : downstream write handshake (gated)
//   sink_eol/sink_eof              : block position tags on the write stream
module upsp_frame_ctrl
  import upsp_pkg::*;
#(
  parameter int DIM_W        = UPSP_DIM_W,
  parameter int BUFFER_WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             src_rvalid,
  output logic             src_rready,
  output logic             core_rvalid,
  input  logic             core_rready,
  input  logic             core_wvalid,
  output logic             core_wready,
  output logic             sink_wvalid,
  input  logic             sink_wready,
  output logic             sink_eol,
  output logic             sink_eof
);

  // Data never passes through this block; the pixel width only matters for
  // the surrounding datapath, so just reject a nonsensical value.
  if (BUFFER_WIDTH < 1) begin : g_bad_buffer_width
    $error("BUFFER_WIDTH must be at least 1");
  end

  upsp_state_e      state_q, state_d;
  logic [DIM_W-1:0] cfg_w_q, cfg_w_d;
  logic [DIM_W-1:0] cfg_h_q, cfg_h_d;
  logic             err_q, err_d;

  logic in_gate, out_gate;
  logic in_hsk, out_hsk;
  logic in_last_x, in_last_y, out_last_x, out_last_y;
  logic in_final, out_final;
  logic start_ok;

  assign in_gate  = (state_q == ST_RUN);
  assign out_gate = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  assign src_rready  = in_gate & core_rready;
  assign core_rvalid = in_gate & src_rvalid;
  assign sink_wvalid = out_gate & core_wvalid;
  assign core_wready = out_gate & sink_wready;

  assign in_hsk  = src_rvalid & src_rready;
  assign out_hsk = sink_wvalid & sink_wready;

  assign sink_eol = out_gate & out_last_x;
  assign sink_eof = sink_eol & out_last_y;

  assign in_final  = in_hsk & in_last_x & in_last_y;
  assign out_final = out_hsk & sink_eof;

  assign start_ok = cfg_start && (state_q == ST_IDLE) &&
                    (cfg_width != '0) && (cfg_height != '0);

  assign busy = out_gate;
  assign done = (state_q == ST_DONE);
  assign err  = err_q;

  upsp_xy_cnt #(.DIM_W(DIM_W)) u_in_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_ok),
    .inc    (in_hsk),
    .max_x  (cfg_w_q - DIM_W'(1)),
    .max_y  (cfg_h_q - DIM_W'(1)),
    .last_x (in_last_x),
    .last_y (in_last_y)
  );

  upsp_xy_cnt #(.DIM_W(DIM_W)) u_out_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_ok),
    .inc    (out_hsk),
    .max_x  (cfg_w_q - DIM_W'(1)),
    .max_y  (cfg_h_q - DIM_W'(1)),
    .last_x (out_last_x),
    .last_y (out_last_y)
  );

  always_comb begin
    state_d = state_q;
    cfg_w_d = cfg_w_q;
    cfg_h_d = cfg_h_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          cfg_w_d = cfg_width;
          cfg_h_d = cfg_height;
          err_d   = 1'b0;
          state_d = ST_RUN;
        end else if (cfg_start) begin
          err_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (cfg_start) err_d = 1'b1;
        // Frame end while input is still open means the core emitted the
        // last block before consuming the last pixel: finish, but flag it.
        if (out_final) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (in_final) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cfg_start) err_d = 1'b1;
        if (out_final) state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Placed last so a stray write valid wins over the clear of a good start.
    if (core_wvalid && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cfg_w_q <= '0;
      cfg_h_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_w_q <= cfg_w_d;
      cfg_h_q <= cfg_h_d;
      err_q   <= err_d;
    end
  end

endmodule
